// File: rtl/seg_scan.sv
// Six-digit multiplexed seven-segment driver: per-frame input snapshot, optional
// leading-zero blanking and a dead interval at the start of every digit slot.
module seg_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYCLES    = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] bcd,
  input  logic [5:0]  dp,
  input  logic        lz_en,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  localparam int unsigned     DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV - 1);
  localparam logic [DivW-1:0] DeadEnd = DivW'(DEAD_CYCLES);
  localparam logic [7:0]      SegInv  = {8{SEG_ACTIVE_LOW}};
  localparam logic [5:0]      SelInv  = {6{SEL_ACTIVE_LOW}};

  logic [DivW-1:0]  div;
  logic [2:0]       idx;
  logic [23:0]      snap_bcd;
  logic [5:0]       snap_dp;
  logic             snap_lz;

  logic [5:0][3:0]  digits;
  logic [5:0]       blank_vec;
  logic [3:0]       digit;
  logic             blank;
  logic             dp_bit;
  logic [5:0]       onehot;
  logic [6:0]       glyph;
  logic             dead;
  logic             frame_start;
  logic [7:0]       seg_nxt;
  logic [5:0]       sel_nxt;

  assign digits      = snap_bcd;
  assign frame_start = (div == '0) && (idx == 3'd0);
  assign dead        = (div < DeadEnd);

  // Digit k is blanked when it and every digit to its left are zero; digit 0 never is.
  always_comb begin
    blank_vec = '0;
    for (int k = 1; k < 6; k++) begin
      blank_vec[k] = snap_lz && ((snap_bcd >> (4 * k)) == 24'd0);
    end
  end

  always_comb begin
    digit  = 4'd0;
    blank  = 1'b0;
    dp_bit = 1'b0;
    onehot = '0;
    for (int i = 0; i < 6; i++) begin
      if (idx == 3'(i)) begin
        digit     = digits[i];
        blank     = blank_vec[i];
        dp_bit    = snap_dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40; // dash flags a non-BCD code
    endcase
  end

  always_comb begin
    seg_nxt = '0;
    sel_nxt = '0;
    if (!dead) begin
      seg_nxt = {dp_bit, blank ? 7'h00 : glyph};
      sel_nxt = onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      idx      <= '0;
      snap_bcd <= '0;
      snap_dp  <= '0;
      snap_lz  <= 1'b0;
      seg      <= SegInv;
      sel      <= SelInv;
    end else begin
      if (frame_start) begin
        snap_bcd <= bcd;
        snap_dp  <= dp;
        snap_lz  <= lz_en;
      end
      if (div == DivMax) begin
        div <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        div <= div + DivW'(1);
      end
      seg <= SegInv ^ seg_nxt;
      sel <= SelInv ^ sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with SCAN_DIV=8, DEAD_CYCLES=2, active-low outputs.
module tb_seg_scan;

  localparam int ScanDiv = 8;
  localparam int Dead    = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [23:0] bcd   = '0;
  logic [5:0]  dp    = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  seg;
  logic [5:0]  sel;

  seg_scan #(
    .SCAN_DIV       (ScanDiv),
    .DEAD_CYCLES    (Dead),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bcd   (bcd),
    .dp    (dp),
    .lz_en (lz_en),
    .seg   (seg),
    .sel   (sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] lit_tab [6];
  int         checks = 0;
  int         passed = 0;

  task automatic set_tab(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                         input logic [7:0] t3, input logic [7:0] t4, input logic [7:0] t5);
    lit_tab[0] = t0;
    lit_tab[1] = t1;
    lit_tab[2] = t2;
    lit_tab[3] = t3;
    lit_tab[4] = t4;
    lit_tab[5] = t5;
  endtask

  // Sample k=0 is the negedge where rst falls; sample k>=1 reflects scan step k-1.
  task automatic push_scan(input int k0, input int n);
    exp_t e;
    int   s;
    int   dv;
    int   ix;
    for (int k = k0; k < k0 + n; k++) begin
      e.sel = 6'h3F;
      e.seg = 8'hFF;
      if (k > 0) begin
        s  = k - 1;
        dv = s % ScanDiv;
        ix = (s / ScanDiv) % 6;
        if (dv >= Dead) begin
          e.sel = 6'h3F ^ (6'h01 << ix);
          e.seg = lit_tab[ix];
        end
      end
      sbq.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    bcd   = 24'h123456;
    dp    = 6'h00;
    lz_en = 1'b0;
    set_tab(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (sel !== 6'h3F || seg !== 8'hFF)
        $display("FAIL reset_hold[%0d]: sel=%h seg=%h expected sel=3f seg=ff", c, sel, seg);
      else passed++;
    end
    rst = 1'b0;
    push_scan(0, 4);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (sel !== e.sel || seg !== e.seg)
        $display("FAIL reset_release[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                 k, sel, seg, e.sel, e.seg);
      else passed++;
    end
  endtask

  task automatic test_scan();
    exp_t e;
    bcd   = 24'h123456;
    dp    = 6'h00;
    lz_en = 1'b0;
    set_tab(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    do_reset(2);
    push_scan(0, 97);
    for (int k = 0; k < 97; k++) begin
      if (k > 0) @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (sel !== e.sel || seg !== e.seg)
        $display("FAIL scan[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                 k, sel, seg, e.sel, e.seg);
      else passed++;
    end
  endtask

  task automatic test_leading_zero();
    exp_t e;
    dp = 6'h00;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          bcd = 24'h000120; lz_en = 1'b1;
          set_tab(8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF);
        end
        1: begin
          bcd = 24'h000000; lz_en = 1'b1;
          set_tab(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        end
        default: begin
          bcd = 24'h000000; lz_en = 1'b0;
          set_tab(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        end
      endcase
      do_reset(1);
      push_scan(0, 49);
      for (int k = 0; k < 49; k++) begin
        if (k > 0) @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (sel !== e.sel || seg !== e.seg)
          $display("FAIL lz%0d[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                   c, k, sel, seg, e.sel, e.seg);
        else passed++;
      end
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    bcd   = 24'h000001;
    dp    = 6'h00;
    lz_en = 1'b0;
    set_tab(8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    do_reset(1);
    push_scan(0, 49);
    lit_tab[0] = 8'h90;
    push_scan(49, 48);
    for (int k = 0; k < 97; k++) begin
      if (k > 0) @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (sel !== e.sel || seg !== e.seg)
        $display("FAIL snapshot[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                 k, sel, seg, e.sel, e.seg);
      else passed++;
      if (k == 28) bcd = 24'h000009; // mid slot 3 of frame 0
    end
  endtask

  task automatic test_invalid_dp();
    exp_t e;
    bcd   = 24'h00000A;
    lz_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      dp = (c == 0) ? 6'b000001 : 6'b000000;
      set_tab((c == 0) ? 8'h3F : 8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      do_reset(1);
      push_scan(0, 49);
      for (int k = 0; k < 49; k++) begin
        if (k > 0) @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (sel !== e.sel || seg !== e.seg)
          $display("FAIL invalid_dp%0d[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                   c, k, sel, seg, e.sel, e.seg);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bcd   = 24'h123456;
    dp    = 6'h00;
    lz_en = 1'b0;
    set_tab(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    do_reset(1);
    push_scan(0, 38);
    for (int k = 0; k < 38; k++) begin
      if (k > 0) @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (sel !== e.sel || seg !== e.seg)
        $display("FAIL mid_pre[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                 k, sel, seg, e.sel, e.seg);
      else passed++;
    end
    // Step 37 is slot 4, div 5; new digits must be picked up by the post-reset snapshot.
    rst = 1'b1;
    bcd = 24'h654321;
    @(negedge clk);
    rst = 1'b0;
    set_tab(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82);
    push_scan(0, 20);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (sel !== e.sel || seg !== e.seg)
        $display("FAIL mid_post[%0d]: sel=%h seg=%h expected sel=%h seg=%h",
                 k, sel, seg, e.sel, e.seg);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_snapshot();
    test_invalid_dp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed six-digit seven-segment display driver that sits directly downstream of the stopwatch timer. It consumes the timer's six BCD digits and drives a common-segment, per-digit-select LED display by time-division scanning. Digit values are snapshotted once per frame to prevent tearing, leading zeros are optionally blanked, and a dead interval between digits suppresses ghosting.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (1 kHz slot rate at 50 MHz); legal range 4..2^20.
- DEAD_CYCLES, 500: cycles at the start of each slot with all selects off; must be < SCAN_DIV.
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are driven low-true.
- SEL_ACTIVE_LOW, 1: 1 means digit-select outputs are driven low-true.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bcd  in  24  six BCD digits; digit i = bcd[4i+3:4i]; digit 0 is rightmost, digit 5 leftmost (matches timer `out[i]`).
- dp  in  6  decimal point request per digit, bit i for digit i.
- lz_en  in  1  leading-zero blanking enable.
- seg  out  8  segments: seg[0]=a … seg[6]=g, seg[7]=dp.
- sel  out  6  one-hot digit select; sel[i] drives digit i.

## Operation
- Divider `div` counts 0..SCAN_DIV-1, wrapping to 0. Slot index `idx` (0..5) increments when div wraps; 5 wraps to 0.
- Frame start: cycle where div==0 and idx==0, including the first cycle after rst deasserts. On frame start, bcd, dp and lz_en are loaded into snapshot registers; the display uses only snapshots. Input changes at any other cycle take effect at the next frame start.
- Slot phases: div < DEAD_CYCLES is dead (sel all inactive, seg all inactive). div >= DEAD_CYCLES is lit (sel[idx] active, seg = decode of snapshot digit idx).
- Decode (active-high form, before polarity): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes A–F show a dash (40) to flag invalid BCD. seg[7] = snapshot dp[idx].
- Leading-zero blanking with snapshot lz_en=1: digit k (k=5..1) is blanked when digits k..5 are all zero. Blanked digit: segments a–g off, dp still honoured, sel still asserted. Digit 0 is never blanked, so all-zero input shows "0".
- Polarity: final seg = SEG_ACTIVE_LOW ? ~v : v. Final sel uses SEL_ACTIVE_LOW in the same way. Inactive therefore means all ones for low-true outputs.
- No state machine beyond div/idx. Only one sel bit is ever active; none is active in a dead phase.

## Timing
- seg and sel are registered. The output in cycle t+1 reflects div/idx/snapshot in cycle t, giving 1-cycle latency.
- While rst is high and in the cycle after it falls: div=0, idx=0, snapshots=0, seg and sel inactive (FF/3F with default polarity).
- Per slot: DEAD_CYCLES inactive cycles, then SCAN_DIV-DEAD_CYCLES active cycles. Frame = 6·SCAN_DIV cycles, scanned in order digit 0,1,2,3,4,5,0….
- Reset mid-slot: the next edge returns everything to the reset state. The scan restarts at digit 0 and the snapshot is reloaded on the first post-reset cycle.
- A snapshot load and a display read in the same cycle: the display uses the old snapshot that cycle and the new one from the next cycle.

## Test plan
(All scenarios use SCAN_DIV=8, DEAD_CYCLES=2 and active-low outputs.)
- Reset: hold rst 3 cycles, then release. While rst is high and one cycle after: seg=FF, sel=3F. The first lit output is sel=3E, 3 cycles after release.
- Scan: bcd=24'h123456, dp=0, lz_en=0. Per slot: 2 cycles sel=3F/seg=FF, then 6 cycles lit. Lit sequence: sel=3E seg=82, 3D/92, 3B/99, 37/B0, 2F/A4, 1F/F9. Repeats every 48 cycles.
- Leading zeros: bcd=24'h000120, lz_en=1. Digits 5,4,3 give seg=FF with sel asserted; digit 2 gives seg=F9; digit 1 gives A4; digit 0 gives C0. With bcd=0, only digit 0 lights, seg=C0. With lz_en=0, all six digits show C0.
- Snapshot: change bcd from 24'h000001 to 24'h000009 during slot 3. The remaining slots of the current frame are unchanged, and digit 0 shows 90 only from the next frame.
- Invalid code and dp: bcd=24'h00000A, dp=6'b000001 gives digit 0 seg=3F (dash plus dp on). With dp=0, digit 0 gives seg=BF.
- Reset mid-operation: assert rst at slot 4, div=5, for 1 cycle. The next cycle shows seg=FF/sel=3F, and the scan resumes at digit 0 after a full 2-cycle dead phase.
